// File: rtl/opendap_ap_mux_pkg.sv
// Shared types and width helpers for the opendap AP interconnect.
// Holds the FSM state encoding, the response-source encoding and a minimum-width helper.
package opendap_ap_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        SRC_LOCAL = 1'b0,
        SRC_AP    = 1'b1
    } src_t;

    // clog2 that never collapses to a zero-width vector
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/opendap_ap_watchdog.sv
// Busy-cycle counter for the AP mux; expire is high in the BUSY cycle that
// completes TIMEOUT_CYCLES cycles without a response. Only instantiated when TIMEOUT_CYCLES > 0.
module opendap_ap_watchdog
    import opendap_ap_mux_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = min_width(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TOP)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/opendap_ap_mux.sv
// Routes the DP's single AP access port to N_APS downstream APs and muxes the
// response back; unmapped/disabled APs are answered locally, hung APs are aborted.
module opendap_ap_mux
    import opendap_ap_mux_pkg::*;
#(
    parameter int unsigned N_APS          = 4,
    parameter logic [7:0]  AP_SEL_BASE    = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter bit          UNMAPPED_ERR   = 1'b0
) (
    input  logic                  swclk,
    input  logic                  rst_n_por,
    input  logic [7:0]            up_sel,
    input  logic [5:0]            up_addr,
    input  logic [31:0]           up_wdata,
    input  logic                  up_wen,
    input  logic                  up_ren,
    input  logic                  up_abort,
    output logic [31:0]           up_rdata,
    output logic                  up_rdy,
    output logic                  up_err,
    input  logic [N_APS-1:0]      ap_en,
    output logic [5:0]            ap_addr,
    output logic [31:0]           ap_wdata,
    output logic [N_APS-1:0]      ap_wen,
    output logic [N_APS-1:0]      ap_ren,
    output logic [N_APS-1:0]      ap_abort,
    input  logic [32*N_APS-1:0]   ap_rdata,
    input  logic [N_APS-1:0]      ap_rdy,
    input  logic [N_APS-1:0]      ap_err,
    output logic                  timeout_evt
);

    // state | meaning
    // IDLE  | ready for a strobe; response comes from src (AP idx or local)
    // BUSY  | AP idx owns an outstanding access; waiting for its rdy

    localparam int unsigned IW = min_width(N_APS);

    state_t          state, state_nxt;
    src_t            src, src_nxt;
    logic            local_err, local_err_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            first;

    logic [8:0]       off;
    logic [N_APS-1:0] sel_hit;
    logic             mapped;
    logic             strobe;
    logic             cur_rdy, cur_en, cur_err;
    logic [31:0]      cur_rdata;
    logic             hang_abort;
    logic             wd_expire;

    // 9-bit subtract so selects below the base never wrap into range
    assign off = {1'b0, up_sel} - {1'b0, AP_SEL_BASE};

    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < N_APS; i++) begin
            sel_hit[i] = (off == 9'(i)) && ap_en[i];
        end
    end

    assign mapped    = |sel_hit;
    assign strobe    = up_wen | up_ren;
    assign cur_rdy   = ap_rdy[idx];
    assign cur_en    = ap_en[idx];
    assign cur_err   = ap_err[idx];
    assign cur_rdata = ap_rdata[32*idx +: 32];

    assign ap_addr  = up_addr;
    assign ap_wdata = up_wdata;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            opendap_ap_watchdog #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_watchdog (
                .clk    (swclk),
                .rst_n  (rst_n_por),
                .clear  ((state == ST_IDLE) || up_abort),
                .enable (state == ST_BUSY),
                .expire (wd_expire)
            );
        end else begin : g_no_wd
            assign wd_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge swclk or negedge rst_n_por) begin
        if (!rst_n_por) begin
            state     <= ST_IDLE;
            src       <= SRC_LOCAL;
            local_err <= 1'b0;
            idx       <= '0;
            first     <= 1'b0;
        end else begin
            state     <= state_nxt;
            src       <= src_nxt;
            local_err <= local_err_nxt;
            idx       <= idx_nxt;
            first     <= (state == ST_IDLE) && (state_nxt == ST_BUSY);
        end
    end

    always_comb begin
        state_nxt     = state;
        src_nxt       = src;
        local_err_nxt = local_err;
        idx_nxt       = idx;
        ap_wen        = '0;
        ap_ren        = '0;
        hang_abort    = 1'b0;
        timeout_evt   = 1'b0;
        up_rdy        = 1'b1;

        case (state)
            ST_IDLE: begin
                up_rdy = (src == SRC_AP) ? cur_rdy : 1'b1;
                if (!up_abort && strobe) begin
                    if (mapped) begin
                        ap_wen    = sel_hit & {N_APS{up_wen}};
                        ap_ren    = sel_hit & {N_APS{up_ren}};
                        idx_nxt   = off[IW-1:0];
                        src_nxt   = SRC_AP;
                        state_nxt = ST_BUSY;
                    end else begin
                        src_nxt       = SRC_LOCAL;
                        local_err_nxt = UNMAPPED_ERR;
                    end
                end
            end
            ST_BUSY: begin
                // the AP only drops rdy the cycle after the strobe, so its rdy is stale here
                up_rdy = first ? 1'b0 : cur_rdy;
                if (up_abort) begin
                    state_nxt = ST_IDLE;
                end else if (!first && cur_rdy) begin
                    state_nxt = ST_IDLE;
                end else if (!cur_en || wd_expire) begin
                    hang_abort    = 1'b1;
                    timeout_evt   = cur_en;
                    src_nxt       = SRC_LOCAL;
                    local_err_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_APS; i++) begin
            ap_abort[i] = up_abort || (hang_abort && (idx == IW'(i)));
        end
    end

    assign up_rdata = (src == SRC_AP) ? cur_rdata : 32'h0;
    assign up_err   = (src == SRC_AP) ? cur_err   : local_err;

endmodule

// File: tb/tb_opendap_ap_mux.sv
// Directed bench for opendap_ap_mux: DUT a has the watchdog and UNMAPPED_ERR=1,
// DUT b has no watchdog and read-as-zero unmapped accesses; both share stimulus.
module tb_opendap_ap_mux;

    logic         swclk = 1'b0;
    logic         rst_n_por;
    logic [7:0]   up_sel;
    logic [5:0]   up_addr;
    logic [31:0]  up_wdata;
    logic         up_wen, up_ren, up_abort;
    logic [3:0]   ap_en;
    logic [127:0] ap_rdata;
    logic [3:0]   ap_rdy, ap_err;

    logic [31:0] a_rdata, b_rdata;
    logic        a_rdy, b_rdy, a_err, b_err, a_evt, b_evt;
    logic [5:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_wen, b_wen, a_ren, b_ren, a_abort, b_abort;

    int passed = 0;
    int total  = 0;

    always #5 swclk = ~swclk;

    opendap_ap_mux #(.N_APS(4), .AP_SEL_BASE(8'h10), .TIMEOUT_CYCLES(8), .UNMAPPED_ERR(1'b1)) u_dut_a (
        .swclk(swclk), .rst_n_por(rst_n_por), .up_sel(up_sel), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
        .up_rdata(a_rdata), .up_rdy(a_rdy), .up_err(a_err), .ap_en(ap_en),
        .ap_addr(a_addr), .ap_wdata(a_wdata), .ap_wen(a_wen), .ap_ren(a_ren),
        .ap_abort(a_abort), .ap_rdata(ap_rdata), .ap_rdy(ap_rdy), .ap_err(ap_err),
        .timeout_evt(a_evt)
    );

    opendap_ap_mux #(.N_APS(4), .AP_SEL_BASE(8'h10), .TIMEOUT_CYCLES(0), .UNMAPPED_ERR(1'b0)) u_dut_b (
        .swclk(swclk), .rst_n_por(rst_n_por), .up_sel(up_sel), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
        .up_rdata(b_rdata), .up_rdy(b_rdy), .up_err(b_err), .ap_en(ap_en),
        .ap_addr(b_addr), .ap_wdata(b_wdata), .ap_wen(b_wen), .ap_ren(b_ren),
        .ap_abort(b_abort), .ap_rdata(ap_rdata), .ap_rdy(ap_rdy), .ap_err(ap_err),
        .timeout_evt(b_evt)
    );

    typedef struct {
        logic [7:0]  sel;
        logic        wen;
        logic        ren;
        logic [3:0]  en;
        logic [3:0]  exp_wen;
        logic [3:0]  exp_ren;
        logic [31:0] exp_rdata;
        logic        exp_err_a;
        logic        exp_err_b;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge swclk);
        #1;
    endtask

    task automatic mid();
        @(negedge swclk);
    endtask

    initial begin
        logic mapped;
        int   bad;

        vecs[0] = '{8'h10, 1'b0, 1'b1, 4'hF, 4'h0, 4'h1, 32'hA000_0000, 1'b0, 1'b0};
        vecs[1] = '{8'h13, 1'b1, 1'b0, 4'hF, 4'h8, 4'h0, 32'hA000_0003, 1'b1, 1'b1};
        vecs[2] = '{8'h0F, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 32'h0,         1'b1, 1'b0};
        vecs[3] = '{8'h14, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 32'h0,         1'b1, 1'b0};
        vecs[4] = '{8'h10, 1'b0, 1'b1, 4'hE, 4'h0, 4'h0, 32'h0,         1'b1, 1'b0};
        vecs[5] = '{8'h11, 1'b0, 1'b1, 4'hE, 4'h0, 4'h2, 32'hA000_0001, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 32'h0,         1'b1, 1'b0};
        vecs[7] = '{8'h12, 1'b1, 1'b0, 4'hF, 4'h4, 4'h0, 32'hA000_0002, 1'b0, 1'b0};

        rst_n_por = 1'b0;
        up_sel = 8'h0; up_addr = 6'h0; up_wdata = 32'h0;
        up_wen = 1'b0; up_ren = 1'b0; up_abort = 1'b0;
        ap_en = 4'hF; ap_rdy = 4'hF; ap_err = 4'b1000;
        ap_rdata = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

        // reset state
        cyc(); cyc();
        mid();
        chk("rst_rdy_a", a_rdy, 1); chk("rst_err_a", a_err, 0); chk("rst_rdata_a", a_rdata, 0);
        chk("rst_strobes_a", {a_wen, a_ren, a_abort, 3'b0, a_evt}, 0);
        chk("rst_rdy_b", b_rdy, 1); chk("rst_rdata_b", b_rdata, 0);
        cyc();
        rst_n_por = 1'b1;

        // table-driven decode and completion
        for (int i = 0; i < 8; i++) begin
            mapped = (vecs[i].exp_wen | vecs[i].exp_ren) != 4'h0;
            cyc();
            up_sel = vecs[i].sel; up_wen = vecs[i].wen; up_ren = vecs[i].ren;
            ap_en = vecs[i].en; up_addr = 6'(i + 3); up_wdata = 32'h5A00_0000 + 32'(i);
            mid();
            chk($sformatf("v%0d_wen_a", i), a_wen, vecs[i].exp_wen);
            chk($sformatf("v%0d_ren_a", i), a_ren, vecs[i].exp_ren);
            chk($sformatf("v%0d_ren_b", i), b_ren | b_wen, vecs[i].exp_wen | vecs[i].exp_ren);
            chk($sformatf("v%0d_bcast", i), {a_addr, a_wdata}, {6'(i + 3), 32'h5A00_0000 + 32'(i)});
            cyc();
            up_wen = 1'b0; up_ren = 1'b0;
            mid();
            chk($sformatf("v%0d_rdy1_a", i), a_rdy, !mapped);
            chk($sformatf("v%0d_rdy1_b", i), b_rdy, !mapped);
            cyc();
            mid();
            chk($sformatf("v%0d_rdy2_a", i), {a_rdy, b_rdy}, 2'b11);
            chk($sformatf("v%0d_rdata_a", i), a_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_rdata_b", i), b_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err_a", i), a_err, vecs[i].exp_err_a);
            chk($sformatf("v%0d_err_b", i), b_err, vecs[i].exp_err_b);
        end
        ap_en = 4'hF;

        // AP2 read with 5 wait cycles
        ap_rdata[95:64] = 32'h0;
        cyc();
        up_sel = 8'h12; up_ren = 1'b1;
        mid();
        chk("ap2_ren", a_ren, 4'b0100);
        cyc();
        up_ren = 1'b0; ap_rdy[2] = 1'b0;
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            mid();
            if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || a_ren !== 4'h0) bad++;
            if (k < 5) cyc();
        end
        chk("ap2_wait_low", bad, 0);
        cyc();
        ap_rdy[2] = 1'b1; ap_rdata[95:64] = 32'hCAFE_F00D;
        mid();
        chk("ap2_done_rdy", {a_rdy, b_rdy}, 2'b11);
        chk("ap2_done_rdata", a_rdata, 32'hCAFE_F00D);
        cyc();
        mid();
        chk("ap2_idle_rdata_b", b_rdata, 32'hCAFE_F00D);
        chk("ap2_idle_err", {a_err, b_err}, 2'b00);
        chk("ap2_idle_rdy", a_rdy, 1);

        // watchdog on AP1
        cyc();
        up_sel = 8'h11; up_ren = 1'b1;
        mid();
        chk("wd_ren", a_ren, 4'b0010);
        cyc();
        up_ren = 1'b0; ap_rdy[1] = 1'b0;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            mid();
            if (k < 8) begin
                if (a_abort !== 4'h0 || a_evt !== 1'b0) bad++;
                cyc();
            end
        end
        chk("wd_early_abort", bad, 0);
        chk("wd_abort_a", a_abort, 4'b0010);
        chk("wd_evt_a", a_evt, 1);
        chk("wd_abort_b", {b_abort, 3'b0, b_evt}, 0);
        cyc();
        mid();
        chk("wd_after_pulse", {a_abort, 3'b0, a_evt}, 0);
        chk("wd_after_rdy", a_rdy, 1);
        chk("wd_after_err", a_err, 1);
        chk("wd_after_rdata", a_rdata, 0);
        chk("wd_b_busy", b_rdy, 0);
        cyc();
        ap_rdy[1] = 1'b1; ap_rdata[63:32] = 32'h1234_5678;
        mid();
        chk("wd_late_a", {a_rdy, a_err, a_rdata}, {2'b11, 32'h0});
        chk("wd_late_b", {b_rdy, b_rdata}, {1'b1, 32'h1234_5678});
        cyc();
        mid();
        chk("wd_late_a2", {a_rdy, a_err, a_rdata}, {2'b11, 32'h0});

        // up_abort during BUSY on AP3
        cyc();
        up_sel = 8'h13; up_ren = 1'b1;
        cyc();
        up_ren = 1'b0; ap_rdy[3] = 1'b0;
        cyc(); cyc();
        up_abort = 1'b1;
        mid();
        chk("abort_all_a", a_abort, 4'hF);
        chk("abort_all_b", b_abort, 4'hF);
        chk("abort_no_evt", a_evt, 0);
        cyc();
        up_abort = 1'b0;
        mid();
        chk("abort_pulse_end", a_abort, 0);
        chk("abort_rdy_follow", {a_rdy, b_rdy}, 2'b00);
        cyc();
        up_sel = 8'h10; up_ren = 1'b1;
        mid();
        chk("abort_then_idle", a_ren, 4'b0001);
        chk("abort_idle_rdy", a_rdy, 0);
        cyc();
        up_ren = 1'b0; ap_rdy[3] = 1'b1;
        cyc(); cyc();

        // abort beats a same-cycle strobe
        up_abort = 1'b1; up_sel = 8'h11; up_ren = 1'b1;
        mid();
        chk("abort_drop_ren", {a_ren, b_ren}, 8'h0);
        chk("abort_drop_abort", a_abort, 4'hF);
        cyc();
        up_abort = 1'b0; up_ren = 1'b0;
        mid();
        chk("abort_drop_state", a_rdy, 1);

        // up_abort coinciding with watchdog expiry
        cyc();
        up_sel = 8'h11; up_ren = 1'b1;
        cyc();
        up_ren = 1'b0; ap_rdy[1] = 1'b0;
        for (int k = 1; k < 8; k++) cyc();
        up_abort = 1'b1;
        mid();
        chk("coin_abort", a_abort, 4'hF);
        chk("coin_no_evt", a_evt, 0);
        cyc();
        up_abort = 1'b0;
        mid();
        chk("coin_src_kept", {a_rdy, a_err, a_rdata}, {2'b00, 32'h1234_5678});
        cyc();
        ap_rdy[1] = 1'b1;

        // ap_en[2] cleared mid-BUSY
        cyc();
        up_sel = 8'h12; up_ren = 1'b1;
        cyc();
        up_ren = 1'b0; ap_rdy[2] = 1'b0;
        cyc();
        ap_en[2] = 1'b0;
        mid();
        chk("endrop_abort_a", a_abort, 4'b0100);
        chk("endrop_abort_b", b_abort, 4'b0100);
        chk("endrop_no_evt", {a_evt, b_evt}, 2'b00);
        cyc();
        ap_en = 4'hF;
        mid();
        chk("endrop_a", {a_rdy, a_err, a_rdata}, {2'b11, 32'h0});
        chk("endrop_b", {b_rdy, b_err, b_rdata}, {2'b11, 32'h0});
        cyc();
        ap_rdy[2] = 1'b1;

        // reset in the middle of BUSY
        cyc();
        up_sel = 8'h13; up_ren = 1'b1;
        cyc();
        up_ren = 1'b0; ap_rdy[3] = 1'b0;
        cyc();
        #1;
        rst_n_por = 1'b0;
        #1;
        chk("rst_busy_a", {a_rdy, a_err, a_rdata}, {2'b10, 32'h0});
        chk("rst_busy_b", {b_rdy, b_err, b_rdata}, {2'b10, 32'h0});
        cyc();
        rst_n_por = 1'b1;
        ap_rdy = 4'hF;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
